// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU operation sequencer.
//  - Opcode encodings understood by the downstream ALU (OP_ADD..OP_DIV).
//  - Sequencer state encoding.
//  - Helper telling which opcodes produce a meaningful HI result.
package alu_ctrl_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_NEG  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_SHRA = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_ROR  = 4'd9;
  localparam logic [3:0] OP_ROL  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_DIV  = 4'd12;
  localparam logic [3:0] OP_LAST = 4'd12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // MUL and DIV are the only ops whose HI output is architecturally written.
  function automatic logic op_writes_hi(input logic [3:0] opcode);
    return (opcode == OP_MUL) || (opcode == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational classifier for an incoming ALU request.
// Ports:
//  i_opcode       opcode of the request
//  i_b            operand B (needed for divide-by-zero detection)
//  o_legal        opcode is one the ALU implements
//  o_div_by_zero  DIV with B == 0
//  o_writes_hi    op updates the HI register
//  o_cycles       number of exec cycles the ALU needs (0 for illegal ops)
module alu_op_decode
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned BASIC_CYCLES = 1,
  parameter int unsigned MUL_CYCLES   = 2,
  parameter int unsigned DIV_CYCLES   = 4
) (
  input  logic [3:0]  i_opcode,
  input  logic [31:0] i_b,
  output logic        o_legal,
  output logic        o_div_by_zero,
  output logic        o_writes_hi,
  output logic [7:0]  o_cycles
);

  // Classify the opcode and look up its exec latency.
  always_comb begin
    o_legal       = 1'b0;
    o_div_by_zero = 1'b0;
    o_writes_hi   = 1'b0;
    o_cycles      = 8'd0;
    if (i_opcode <= OP_LAST) begin
      o_legal       = 1'b1;
      o_div_by_zero = (i_opcode == OP_DIV) && (i_b == 32'd0);
      o_writes_hi   = op_writes_hi(i_opcode);
      case (i_opcode)
        OP_MUL:  o_cycles = 8'(MUL_CYCLES);
        OP_DIV:  o_cycles = 8'(DIV_CYCLES);
        default: o_cycles = 8'(BASIC_CYCLES);
      endcase
    end else begin
      o_legal       = 1'b0;
      o_div_by_zero = 1'b0;
      o_writes_hi   = 1'b0;
      o_cycles      = 8'd0;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer in front of a combinational HI/LO ALU.
// Accepts one request per handshake, holds opcode/operands/exec stable for
// the op's latency, captures LO/HI, and returns a response with HI/LO
// register write pulses on the response handshake.
// Ports:
//  clock, clear                 rising-edge clock, synchronous active-low reset
//  req_valid/req_ready          request handshake (ready only in IDLE)
//  req_opcode/req_a/req_b       request payload
//  alu_opcode/alu_exec/alu_a/b  drive to the ALU (from latched regs)
//  alu_result/alu_hi            ALU LO and HI results
//  rsp_valid/rsp_ready          response handshake
//  rsp_lo/rsp_hi/rsp_err        captured response
//  lo_we/hi_we                  register write pulses on the response handshake
//  busy                         sequencer not in IDLE
module alu_op_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned BASIC_CYCLES = 1,
  parameter int unsigned MUL_CYCLES   = 2,
  parameter int unsigned DIV_CYCLES   = 4
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_opcode,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [3:0]  alu_opcode,
  output logic        alu_exec,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_hi,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_lo,
  output logic [31:0] rsp_hi,
  output logic        rsp_err,
  output logic        lo_we,
  output logic        hi_we,
  output logic        busy
);

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_opcode;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [7:0]  r_cnt;
  logic [31:0] r_rsp_lo;
  logic [31:0] r_rsp_hi;
  logic        r_rsp_err;
  logic        r_writes_hi;

  logic        w_legal;
  logic        w_div_by_zero;
  logic        w_writes_hi;
  logic [7:0]  w_cycles;
  logic        w_req_ready;
  logic        w_exec;
  logic        w_rsp_valid;
  logic        w_lo_we;
  logic        w_hi_we;
  logic        w_accept;

  alu_op_decode #(
    .BASIC_CYCLES (BASIC_CYCLES),
    .MUL_CYCLES   (MUL_CYCLES),
    .DIV_CYCLES   (DIV_CYCLES)
  ) u_decode (
    .i_opcode      (req_opcode),
    .i_b           (req_b),
    .o_legal       (w_legal),
    .o_div_by_zero (w_div_by_zero),
    .o_writes_hi   (w_writes_hi),
    .o_cycles      (w_cycles)
  );

  // Next-state and handshake/strobe decode for the sequencer FSM.
  always_comb begin
    w_next_state = r_state;
    w_req_ready  = 1'b0;
    w_exec       = 1'b0;
    w_rsp_valid  = 1'b0;
    w_lo_we      = 1'b0;
    w_hi_we      = 1'b0;
    case (r_state)
      IDLE: begin
        w_req_ready = 1'b1;
        if (req_valid) begin
          // Illegal ops and divide-by-zero answer immediately without touching the ALU.
          if (!w_legal || w_div_by_zero) begin
            w_next_state = RESP;
          end else begin
            w_next_state = EXEC;
          end
        end else begin
          w_next_state = IDLE;
        end
      end
      EXEC: begin
        w_exec = 1'b1;
        if (r_cnt == 8'd0) begin
          w_next_state = RESP;
        end else begin
          w_next_state = EXEC;
        end
      end
      RESP: begin
        w_rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_lo_we      = !r_rsp_err;
          w_hi_we      = !r_rsp_err && r_writes_hi;
          w_next_state = IDLE;
        end else begin
          w_next_state = RESP;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign w_accept = w_req_ready && req_valid;

  // State, operand latch, latency counter and response capture.
  always_ff @(posedge clock) begin
    if (!clear) begin
      r_state     <= IDLE;
      r_opcode    <= 4'd0;
      r_a         <= 32'd0;
      r_b         <= 32'd0;
      r_cnt       <= 8'd0;
      r_rsp_lo    <= 32'd0;
      r_rsp_hi    <= 32'd0;
      r_rsp_err   <= 1'b0;
      r_writes_hi <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_opcode    <= req_opcode;
            r_a         <= req_a;
            r_b         <= req_b;
            r_writes_hi <= w_writes_hi;
            if (!w_legal) begin
              r_rsp_lo  <= 32'd0;
              r_rsp_hi  <= 32'd0;
              r_rsp_err <= 1'b1;
            end else if (w_div_by_zero) begin
              r_rsp_lo  <= 32'hFFFF_FFFF;
              r_rsp_hi  <= req_a;
              r_rsp_err <= 1'b1;
            end else begin
              r_cnt <= w_cycles - 8'd1;
            end
          end
        end
        EXEC: begin
          if (r_cnt == 8'd0) begin
            r_rsp_lo  <= alu_result;
            r_rsp_hi  <= alu_hi;
            r_rsp_err <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // Handshakes and strobes are forced low while clear is asserted, even
  // before the synchronous reset edge has returned the FSM to IDLE.
  assign req_ready  = clear && w_req_ready;
  assign alu_exec   = clear && w_exec;
  assign rsp_valid  = clear && w_rsp_valid;
  assign lo_we      = clear && w_lo_we;
  assign hi_we      = clear && w_hi_we;
  assign busy       = (r_state != IDLE);

  assign alu_opcode = r_opcode;
  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign rsp_lo     = r_rsp_lo;
  assign rsp_hi     = r_rsp_hi;
  assign rsp_err    = r_rsp_err;

endmodule
